// File: rtl/apb_requester_arb.sv
// apb_requester_arb: two-requester round-robin front end for a single APB requester port.
// Rev 1.0 - initial release.
`default_nettype none

module apb_requester_arb #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic [1:0]            req,
  input  logic [1:0]            write,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic                  err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic                  pready,
  input  logic [DATA_W-1:0]     prdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_wait_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ptr;
  logic [CNT_W-1:0]    r_wait;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;

  logic [1:0]          w_elig;
  logic [1:0]          w_pick;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_complete;
  logic                w_timeout;

  // A requester just signalled done may still hold req this cycle; keep it out.
  always_comb begin
    w_elig      = req & ~r_done;
    w_pick      = w_elig;
    if (w_elig == 2'b11) begin
      w_pick = r_ptr ? 2'b10 : 2'b01;
    end
    w_sel_write = w_pick[1] ? write[1] : write[0];
    w_sel_addr  = w_pick[1] ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    w_sel_wdata = w_pick[1] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    w_complete  = (r_state == ST_ACCESS) && pready;
    w_timeout   = (TIMEOUT > 0) && (r_state == ST_ACCESS) && !pready &&
                  (r_wait == c_wait_last);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_pick != 2'b00) w_next_state = ST_SETUP;
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: if (w_complete || w_timeout) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_ptr    <= 1'b0;
      r_wait   <= '0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 2'b00;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick != 2'b00) begin
            r_gnt    <= w_pick;
            r_pwrite <= w_sel_write;
            r_paddr  <= w_sel_addr;
            r_pwdata <= w_sel_wdata;
            r_wait   <= '0;
          end
        end
        ST_ACCESS: begin
          if (w_complete) begin
            r_done <= r_gnt;
            r_gnt  <= 2'b00;
            r_ptr  <= ~r_ptr;
            if (!r_pwrite) r_rdata <= prdata;
          end else if (w_timeout) begin
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_gnt   <= 2'b00;
            r_ptr   <= ~r_ptr;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable = (r_state == ST_ACCESS);
  assign gnt     = r_gnt;
  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_requester_arb.sv
// tb_apb_requester_arb: scoreboard bench for apb_requester_arb (TIMEOUT=4).
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module tb_apb_requester_arb;

  logic        pclk = 1'b0;
  logic        prst;
  logic [1:0]  req, write, gnt, done;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        err, psel, penable, pwrite, pready;
  logic [7:0]  rdata, pwdata, prdata;
  logic [3:0]  paddr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] q_g[$];   // {gnt, pwrite, paddr, pwdata}
  logic [10:0] q_d[$];   // {done, err, rdata}
  logic [7:0]  m_rdata;
  logic [12:0] lat;
  logic        prev_psel = 1'b0;

  apb_requester_arb #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(4)) dut (
    .pclk(pclk), .prst(prst), .req(req), .write(write), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_g(input logic [1:0] g, input logic w, input logic [3:0] a, input logic [7:0] d);
    q_g.push_back({g, w, a, d});
  endtask

  task automatic push_d(input logic [1:0] dn, input logic e, input logic [7:0] rd);
    q_d.push_back({dn, e, rd});
  endtask

  // Monitor: grants checked at SETUP, operands held during ACCESS, completions on done.
  always @(negedge pclk) begin
    if (psel && !penable) begin
      chk("idle_gap", {31'b0, prev_psel}, 32'd0);
      if (q_g.size() == 0) chk("grant_unexpected", {30'b0, gnt}, 32'd0);
      else chk("grant", {17'b0, gnt, pwrite, paddr, pwdata}, {17'b0, q_g.pop_front()});
      lat = {pwrite, paddr, pwdata};
    end
    if (penable) chk("hold", {19'b0, pwrite, paddr, pwdata}, {19'b0, lat});
    if (done != 2'b00) begin
      if (q_d.size() == 0) chk("done_unexpected", {30'b0, done}, 32'd0);
      else chk("done", {21'b0, done, err, rdata}, {21'b0, q_d.pop_front()});
    end
    prev_psel = psel;
  end

  // Drives pready (low for n_wait ACCESS cycles) and collects done pulses.
  task automatic run_xfers(input int n_done, input int n_wait, input bit drop, input int max_cyc,
                           output int pen);
    int acc = 0;
    int got = 0;
    pen = 0;
    for (int c = 0; c < max_cyc && got < n_done; c++) begin
      @(negedge pclk);
      if (penable) begin
        acc++;
        pen++;
        pready = (acc > n_wait);
      end else begin
        pready = 1'b0;
      end
      if (done != 2'b00) begin
        got++;
        acc = 0;
        if (drop) req = req & ~done;
      end
    end
    if (got < n_done) chk("xfer_bound", got, n_done);
  endtask

  task automatic do_reset();
    prst = 1'b1;
    req  = 2'b00;
    pready = 1'b0;
    repeat (2) @(negedge pclk);
    m_rdata = 8'h00;
    prst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pen;
    prst = 1'b1; req = 0; write = 0; addr = 0; wdata = 0; pready = 0; prdata = 0;
    m_rdata = 8'h00;
    repeat (3) @(negedge pclk);
    chk("rst_ctrl", {26'b0, psel, penable, pwrite, gnt, err}, 32'd0);
    chk("rst_done", {30'b0, done}, 32'd0);
    chk("rst_data", {12'b0, paddr, pwdata, rdata}, 32'd0);
    prst = 1'b0;

    // Single write, minimum latency; req held through the done cycle.
    req = 2'b01; write = 2'b01; addr = 8'h03; wdata = 16'h00A5; pready = 1'b1;
    push_g(2'b01, 1'b1, 4'h3, 8'hA5); push_d(2'b01, 1'b0, 8'h00);
    @(negedge pclk); chk("t1_setup",  {30'b0, psel, penable}, 32'd2);
    @(negedge pclk); chk("t1_access", {30'b0, psel, penable}, 32'd3);
    chk("t1_ops", {19'b0, pwrite, paddr, pwdata}, {19'b0, 1'b1, 4'h3, 8'hA5});
    @(negedge pclk); chk("t1_done", {29'b0, done, err}, 32'd2);
    @(negedge pclk); chk("t1_pulse_regrant", {29'b0, done, psel}, 32'd0);
    req = 2'b00;
    @(negedge pclk); chk("t1_idle", {31'b0, psel}, 32'd0);

    // Contention from a fresh pointer.
    do_reset();
    req = 2'b11; write = 2'b01; addr = {4'h9, 4'h7}; wdata = {8'h00, 8'h11}; prdata = 8'h3C;
    push_g(2'b01, 1'b1, 4'h7, 8'h11); push_d(2'b01, 1'b0, m_rdata);
    push_g(2'b10, 1'b0, 4'h9, 8'h00); push_d(2'b10, 1'b0, 8'h3C); m_rdata = 8'h3C;
    run_xfers(2, 0, 1'b1, 60, pen);
    chk("t2_pen", pen, 32'd2);

    // Three wait states.
    req = 2'b10; write = 2'b10; addr = {4'h5, 4'h0}; wdata = {8'h5A, 8'h00};
    push_g(2'b10, 1'b1, 4'h5, 8'h5A); push_d(2'b10, 1'b0, m_rdata);
    run_xfers(1, 3, 1'b1, 60, pen);
    chk("t3_pen", pen, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk); chk("t3_single_done", {30'b0, done}, 32'd0);
    end

    // Timeout after 4 ACCESS cycles.
    req = 2'b01; write = 2'b00; addr = {4'h0, 4'h2}; wdata = 16'h0000;
    push_g(2'b01, 1'b0, 4'h2, 8'h00); push_d(2'b01, 1'b1, 8'h00); m_rdata = 8'h00;
    run_xfers(1, 1000, 1'b1, 60, pen);
    chk("t4_pen", pen, 32'd4);
    chk("t4_psel", {31'b0, psel}, 32'd0);
    chk("t4_err", {31'b0, err}, 32'd1);

    // Reset in the middle of ACCESS, then release into contention.
    repeat (2) @(negedge pclk);
    req = 2'b10; write = 2'b00; addr = {4'h4, 4'h0}; pready = 1'b0;
    push_g(2'b10, 1'b0, 4'h4, 8'h00);
    for (int i = 0; i < 20 && !penable; i++) @(negedge pclk);
    chk("t5_reached_access", {31'b0, penable}, 32'd1);
    @(negedge pclk);
    prst = 1'b1;
    @(negedge pclk);
    chk("t5_abort", {27'b0, psel, penable, gnt, 1'b0}, 32'd0);
    chk("t5_nodone", {30'b0, done}, 32'd0);
    m_rdata = 8'h00;
    req = 2'b11; write = 2'b01; addr = {4'h2, 4'h1}; wdata = {8'h22, 8'h11}; prdata = 8'h5E;
    prst = 1'b0;

    // Fairness with req held high for six transfers.
    for (int i = 0; i < 3; i++) begin
      push_g(2'b01, 1'b1, 4'h1, 8'h11); push_d(2'b01, 1'b0, m_rdata);
      push_g(2'b10, 1'b0, 4'h2, 8'h22); push_d(2'b10, 1'b0, 8'h5E); m_rdata = 8'h5E;
    end
    run_xfers(6, 0, 1'b0, 200, pen);
    req = 2'b00;
    chk("t6_pen", pen, 32'd6);
    repeat (4) @(negedge pclk);
    chk("q_grant_empty", q_g.size(), 32'd0);
    chk("q_done_empty", q_d.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
